eth_tx_framer: RTL and testbench

//  Builds complete Ethernet frames ahead of the RGMII DDR transmit stage: adds preamble, SFD,
//  pad to minimum size, CRC32 FCS and inter-frame gap around a payload byte stream.

---
 rtl/eth_tx_framer_pkg.sv | 37 +++
 rtl/eth_tx_framer_if.sv | 17 +
 rtl/eth_tx_framer_crc32.sv | 42 ++++
 rtl/eth_tx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_tx_framer_pkg.sv
// Shared definitions for the Ethernet transmit framer.
// Holds the fixed frame bytes, the CRC32 constants, the default frame size
// limits, the framer state encoding and the byte-wide CRC32 update function.
package eth_tx_framer_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

  localparam int unsigned ETH_MIN_PAYLOAD = 60;
  localparam int unsigned ETH_MAX_PAYLOAD = 1514;
  localparam int unsigned ETH_IFG_BYTES   = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } txState_e;

  // Reflected CRC32: the byte enters at the LSB end and eight shift/xor
  // steps are unrolled into one combinational update.
  function automatic logic [31:0] crc32Byte(input logic [31:0] crcIn,
                                            input logic [7:0]  dataIn);
    logic [31:0] c;
    c = crcIn ^ {24'h000000, dataIn};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload byte stream from the packet source into the framer.
//   s_data  : payload byte
//   s_valid : s_data valid
//   s_last  : final payload byte of the frame
//   s_ready : byte accepted this cycle when s_valid && s_ready
// The master modport is the packet source, the slave modport is the framer.
interface eth_tx_framer_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/eth_tx_framer_crc32.sv
// CRC32 accumulator for the framer's FCS.
//   i_clk, i_rstn : transmit clock, asynchronous active-low reset
//   i_init        : load the CRC seed (takes priority over i_en)
//   i_en          : absorb i_data into the running CRC
//   i_data        : byte to absorb
//   o_crc         : running CRC register (not inverted)
module eth_crc32
  import eth_tx_framer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Seeding wins over absorbing so a new frame can start without a
  // separate clear cycle.
  always_comb begin
    crc_d = crc_q;
    if (i_init) begin
      crc_d = ETH_CRC_INIT;
    end else if (i_en) begin
      crc_d = crc32Byte(crc_q, i_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      crc_q <= ETH_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a payload byte stream with preamble, SFD,
// zero padding, CRC32 FCS and inter-frame gap, one byte per clock.
//   i_clk, i_rstn : 125 MHz transmit clock, asynchronous active-low reset
//   s             : payload stream (slave side of eth_tx_framer_if)
//   o_data        : registered frame byte to the DDR stage
//   o_en          : registered TX_EN
//   o_er          : registered TX_ER
//   o_busy        : framer is not idle
//   o_underrun    : registered one-cycle pulse when a frame is abandoned
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD,
  parameter int unsigned IFG_BYTES   = ETH_IFG_BYTES
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  eth_tx_framer_if.slave  s,
  output logic [7:0]      o_data,
  output logic            o_en,
  output logic            o_er,
  output logic            o_busy,
  output logic            o_underrun
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  // The IDLE start cycle already emits the first preamble byte, so PRE
  // only has to cover the remaining six.
  localparam logic [2:0]  PRE_LAST = 3'd5;

  txState_e    state_q, state_d;
  logic [10:0] payloadCnt_q, payloadCnt_d;
  logic [2:0]  preCnt_q, preCnt_d;
  logic [1:0]  fcsIdx_q, fcsIdx_d;
  logic [7:0]  ifgCnt_q, ifgCnt_d;
  logic        truncErr_q, truncErr_d;

  logic [7:0]  dataOut_q, dataOut_d;
  logic        enOut_q, enOut_d;
  logic        erOut_q, erOut_d;
  logic        underrunOut_q, underrunOut_d;

  logic        crcInit;
  logic        crcEn;
  logic [7:0]  crcByte;
  logic [31:0] crcValue;
  logic [31:0] fcsValue;
  logic [10:0] cntInc;

  eth_crc32 u_crc (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_init (crcInit),
    .i_en   (crcEn),
    .i_data (crcByte),
    .o_crc  (crcValue)
  );

  assign fcsValue = ~crcValue;
  assign cntInc   = payloadCnt_q + 11'd1;

  // State register plus every counter and the registered output stage.
  // Reset abandons whatever frame is in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      payloadCnt_q  <= '0;
      preCnt_q      <= '0;
      fcsIdx_q      <= '0;
      ifgCnt_q      <= '0;
      truncErr_q    <= 1'b0;
      dataOut_q     <= '0;
      enOut_q       <= 1'b0;
      erOut_q       <= 1'b0;
      underrunOut_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      payloadCnt_q  <= payloadCnt_d;
      preCnt_q      <= preCnt_d;
      fcsIdx_q      <= fcsIdx_d;
      ifgCnt_q      <= ifgCnt_d;
      truncErr_q    <= truncErr_d;
      dataOut_q     <= dataOut_d;
      enOut_q       <= enOut_d;
      erOut_q       <= erOut_d;
      underrunOut_q <= underrunOut_d;
    end
  end

  // Next-state and counter logic. s_last wins over the size limit, so a
  // frame that ends exactly at MAX_PAYLOAD is still a good frame.
  always_comb begin
    state_d      = state_q;
    payloadCnt_d = payloadCnt_q;
    preCnt_d     = preCnt_q;
    fcsIdx_d     = fcsIdx_q;
    ifgCnt_d     = ifgCnt_q;
    truncErr_d   = truncErr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s.s_valid) begin
          state_d      = ST_PRE;
          payloadCnt_d = '0;
          preCnt_d     = '0;
          fcsIdx_d     = '0;
          truncErr_d   = 1'b0;
        end
      end
      ST_PRE: begin
        preCnt_d = preCnt_q + 3'd1;
        if (preCnt_q == PRE_LAST) begin
          state_d = ST_SFD;
        end
      end
      ST_SFD: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s.s_valid) begin
          payloadCnt_d = cntInc;
          if (s.s_last) begin
            state_d = (cntInc < MIN_CNT) ? ST_PAD : ST_FCS;
          end else if (cntInc == MAX_CNT) begin
            state_d    = ST_FCS;
            truncErr_d = 1'b1;
          end
        end else begin
          state_d  = ST_IFG;
          ifgCnt_d = '0;
        end
      end
      ST_PAD: begin
        payloadCnt_d = cntInc;
        if (cntInc == MIN_CNT) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        fcsIdx_d = fcsIdx_q + 2'd1;
        if (fcsIdx_q == 2'd3) begin
          state_d  = ST_IFG;
          ifgCnt_d = '0;
        end
      end
      ST_IFG: begin
        ifgCnt_d = ifgCnt_q + 8'd1;
        if (ifgCnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: what the output registers load at the next edge and
  // which byte the CRC absorbs. Pad bytes are zeros and are covered by
  // the CRC; the FCS goes out least-significant byte first.
  always_comb begin
    dataOut_d     = '0;
    enOut_d       = 1'b0;
    erOut_d       = 1'b0;
    underrunOut_d = 1'b0;
    crcInit       = 1'b0;
    crcEn         = 1'b0;
    crcByte       = s.s_data;
    unique case (state_q)
      ST_IDLE: begin
        if (s.s_valid) begin
          dataOut_d = ETH_PREAMBLE;
          enOut_d   = 1'b1;
          crcInit   = 1'b1;
        end
      end
      ST_PRE: begin
        dataOut_d = ETH_PREAMBLE;
        enOut_d   = 1'b1;
      end
      ST_SFD: begin
        dataOut_d = ETH_SFD;
        enOut_d   = 1'b1;
      end
      ST_DATA: begin
        enOut_d = 1'b1;
        if (s.s_valid) begin
          dataOut_d = s.s_data;
          crcEn     = 1'b1;
        end else begin
          erOut_d       = 1'b1;
          underrunOut_d = 1'b1;
        end
      end
      ST_PAD: begin
        enOut_d = 1'b1;
        crcEn   = 1'b1;
        crcByte = 8'h00;
      end
      ST_FCS: begin
        enOut_d   = 1'b1;
        erOut_d   = truncErr_q;
        dataOut_d = fcsValue[{fcsIdx_q, 3'b000} +: 8];
      end
      default: begin
      end
    endcase
  end

  assign s.s_ready  = (state_q == ST_DATA);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_data     = dataOut_q;
  assign o_en       = enOut_q;
  assign o_er       = erOut_q;
  assign o_underrun = underrunOut_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: a frame-level reference model turns
// each payload transaction into the expected per-cycle output sequence, and
// one compare process checks every cycle against it.
module tb_eth_tx_framer;

  localparam int MIN_P   = 60;
  localparam int MAX_P   = 1514;
  localparam int IFG_B   = 12;
  localparam int K_GOOD  = 0;
  localparam int K_UNDER = 1;
  localparam int K_TRUNC = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       er;
    logic       und;
    logic       busy;
  } ent_t;

  typedef struct {
    int kind;
    int nAcc;
  } desc_t;

  typedef logic [7:0] bq_t[$];

  logic        i_clk  = 1'b0;
  logic        i_rstn = 1'b1;
  logic [7:0]  o_data;
  logic        o_en;
  logic        o_er;
  logic        o_busy;
  logic        o_underrun;

  logic        cuInit = 1'b0;
  logic        cuEn   = 1'b0;
  logic [7:0]  cuData = 8'h00;
  logic [31:0] cuCrc;

  int checks = 0;
  int errors = 0;

  ent_t       expQ[$];
  desc_t      descQ[$];
  logic [7:0] payQ[$];

  int run         = 0;
  int lastRun     = 0;
  int gap         = 0;
  int lastGap     = 0;
  int underrunCnt = 0;

  eth_tx_framer_if sIf ();

  eth_tx_framer #(
    .MIN_PAYLOAD (MIN_P),
    .MAX_PAYLOAD (MAX_P),
    .IFG_BYTES   (IFG_B)
  ) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .s          (sIf),
    .o_data     (o_data),
    .o_en       (o_en),
    .o_er       (o_er),
    .o_busy     (o_busy),
    .o_underrun (o_underrun)
  );

  eth_crc32 crcUnit (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_init (cuInit),
    .i_en   (cuEn),
    .i_data (cuData),
    .o_crc  (cuCrc)
  );

  always #4 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Standard Ethernet FCS over a byte list (already complemented).
  function automatic logic [31:0] refFcs(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h000000, b[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic bq_t randPayload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Expand the next transaction into the exact output sequence of one frame,
  // including its inter-frame gap; busy drops only in the final gap cycle.
  task automatic pushFrame();
    desc_t       dsc;
    bq_t         body;
    logic [31:0] fcs;
    checkOutput("descAvail", 32'(descQ.size() > 0), 1);
    if (descQ.size() == 0) return;
    dsc = descQ.pop_front();
    for (int i = 0; i < dsc.nAcc; i++) body.push_back(payQ.pop_front());
    for (int i = 0; i < 7; i++) expQ.push_back('{8'h55, 1'b1, 1'b0, 1'b0, 1'b1});
    expQ.push_back('{8'hD5, 1'b1, 1'b0, 1'b0, 1'b1});
    foreach (body[i]) expQ.push_back('{body[i], 1'b1, 1'b0, 1'b0, 1'b1});
    if (dsc.kind == K_UNDER) begin
      expQ.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b1});
    end else begin
      while (dsc.kind == K_GOOD && body.size() < MIN_P) begin
        body.push_back(8'h00);
        expQ.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
      end
      fcs = refFcs(body);
      for (int k = 0; k < 4; k++)
        expQ.push_back('{fcs[8*k +: 8], 1'b1, (dsc.kind == K_TRUNC), 1'b0, 1'b1});
    end
    for (int g = 0; g < IFG_B; g++)
      expQ.push_back('{8'h00, 1'b0, 1'b0, 1'b0, (g != IFG_B - 1)});
  endtask

  // Per-cycle compare against the model, plus o_en run/gap bookkeeping.
  initial begin
    ent_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        expQ.delete();
        run = 0;
        gap = 0;
        checkOutput("resetCycle", {20'h0, o_data, o_en, o_er, o_underrun, o_busy}, 0);
      end else begin
        e = (expQ.size() > 0) ? expQ.pop_front() : '0;
        checkOutput("cycle", {20'h0, o_data, o_en, o_er, o_underrun, o_busy},
                    {20'h0, e});
        if (o_underrun) underrunCnt++;
        if (o_en) begin
          if (run == 0) lastGap = gap;
          run++;
        end else begin
          if (run > 0) begin
            lastRun = run;
            run = 0;
            gap = 0;
          end
          gap++;
        end
        if (expQ.size() == 0 && sIf.s_valid) pushFrame();
      end
    end
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Drive one payload transaction; called and returns at posedge+1.
  task automatic applyStimulus(input int kind, input bq_t bytes);
    int   n;
    int   nAcc;
    int   idx;
    int   guard;
    logic hs;
    n     = bytes.size();
    nAcc  = (kind == K_TRUNC) ? MAX_P : n;
    idx   = 0;
    guard = 0;
    for (int i = 0; i < nAcc; i++) payQ.push_back(bytes[i]);
    descQ.push_back('{kind, nAcc});
    sIf.s_valid = 1'b1;
    sIf.s_data  = bytes[0];
    sIf.s_last  = (kind == K_GOOD && n == 1);
    while (idx < nAcc && guard < 4000) begin
      @(negedge i_clk);
      hs = sIf.s_ready;
      @(posedge i_clk);
      #1;
      guard++;
      if (hs) begin
        idx++;
        if (idx < n) begin
          sIf.s_data = bytes[idx];
          sIf.s_last = (kind == K_GOOD && idx == n - 1);
        end
      end
    end
    if (guard >= 4000) checkOutput("handshakeTimeout", idx, nAcc);
    if (kind == K_TRUNC) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge i_clk);
        checkOutput("stallReady", 32'(sIf.s_ready), 0);
      end
      @(posedge i_clk);
      #1;
    end
    sIf.s_valid = 1'b0;
    sIf.s_data  = 8'h00;
    sIf.s_last  = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || descQ.size() != 0) && guard < 4000) begin
      @(negedge i_clk);
      guard++;
    end
    checkOutput("drainDone", 32'(expQ.size() + descQ.size()), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bq_t        pl;
    bq_t        ascii;
    logic [7:0] fcsBytes[4];
    int         len;
    int         kind;
    int         seen;
    int         guard;
    int         undBefore;

    sIf.s_valid = 1'b0;
    sIf.s_data  = 8'h00;
    sIf.s_last  = 1'b0;
    #1 i_rstn = 1'b0;
    idleCycles(3);
    checkOutput("resetReady", 32'(sIf.s_ready), 0);
    checkOutput("resetOutputs", {23'h0, o_data, o_en, o_er, o_busy, o_underrun}, 0);
    i_rstn = 1'b1;
    idleCycles(2);

    // CRC unit and model pinned to the well-known check value.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcsBytes = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    checkOutput("modelCrcCheck", refFcs(ascii), 32'hCBF43926);
    cuInit = 1'b1;
    idleCycles(1);
    cuInit = 1'b0;
    cuEn   = 1'b1;
    foreach (ascii[i]) begin
      cuData = ascii[i];
      idleCycles(1);
    end
    cuEn = 1'b0;
    checkOutput("crcUnitCheck", ~cuCrc, 32'hCBF43926);
    for (int k = 0; k < 4; k++)
      checkOutput("crcUnitFcsByte", {24'h0, ~cuCrc[8*k +: 8]}, {24'h0, fcsBytes[k]});

    // 60-byte counting payload, then a back-to-back frame to see the gap.
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    applyStimulus(K_GOOD, pl);
    applyStimulus(K_GOOD, randPayload(70));
    checkOutput("run60", lastRun, 72);
    checkOutput("gapBackToBack", lastGap, 12);
    waitIdle();

    // Single byte gets padded to the minimum size.
    pl = '{8'hAB};
    applyStimulus(K_GOOD, pl);
    waitIdle();
    checkOutput("run1", lastRun, 72);

    // Starvation after ten bytes, then a clean frame.
    undBefore = underrunCnt;
    applyStimulus(K_UNDER, randPayload(10));
    waitIdle();
    checkOutput("runUnderrun", lastRun, 19);
    checkOutput("underrunPulses", underrunCnt - undBefore, 1);
    applyStimulus(K_GOOD, randPayload(64));
    waitIdle();
    checkOutput("runAfterUnderrun", lastRun, 76);

    // Oversize payload is cut at the maximum and flagged.
    applyStimulus(K_TRUNC, randPayload(1600));
    waitIdle();
    checkOutput("runTrunc", lastRun, 1526);

    // Reset while the fourth preamble byte is on the wire.
    pl = randPayload(40);
    foreach (pl[i]) payQ.push_back(pl[i]);
    descQ.push_back('{K_GOOD, 40});
    sIf.s_valid = 1'b1;
    sIf.s_data  = pl[0];
    sIf.s_last  = 1'b0;
    seen  = 0;
    guard = 0;
    while (seen < 4 && guard < 40) begin
      @(negedge i_clk);
      #1;
      guard++;
      if (o_en && o_data == 8'h55) seen++;
    end
    checkOutput("preambleSeen", seen, 4);
    i_rstn      = 1'b0;
    sIf.s_valid = 1'b0;
    #1;
    checkOutput("midResetOutputs", {23'h0, o_data, o_en, o_er, o_busy, o_underrun}, 0);
    checkOutput("midResetReady", 32'(sIf.s_ready), 0);
    payQ.delete();
    descQ.delete();
    idleCycles(3);
    i_rstn = 1'b1;
    idleCycles(1);
    applyStimulus(K_GOOD, randPayload(45));
    waitIdle();
    checkOutput("runAfterReset", lastRun, 72);

    // Randomized mix of lengths around the padding boundary and underruns.
    for (int f = 0; f < 20; f++) begin
      kind = ($urandom_range(0, 4) == 0) ? K_UNDER : K_GOOD;
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 10);
        1:       len = $urandom_range(58, 62);
        default: len = $urandom_range(1, 120);
      endcase
      if (kind == K_UNDER) len = $urandom_range(1, 40);
      applyStimulus(kind, randPayload(len));
      idleCycles($urandom_range(0, 15));
    end
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
